// File: rtl/steering_pwm_gen.sv
// Servo steering PWM generator: clamps PID commands to a target deviation and slews the
// applied pulse width toward it once per PWM period.
module steering_pwm_gen #(
    parameter int PERIOD_CYCLES = 2000000,
    parameter int CENTER_CYCLES = 150000,
    parameter int MAX_DEV       = 50000,
    parameter int SLEW_STEP     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic        i_pid_valid,
    input  logic [47:0] i_pid_output,
    output logic        o_pwm,
    output logic        o_period_start,
    output logic [31:0] o_width,
    output logic        o_saturated
);

    if (CENTER_CYCLES < MAX_DEV || CENTER_CYCLES + MAX_DEV >= PERIOD_CYCLES ||
        SLEW_STEP < 1 || MAX_DEV < 0) begin : g_param_check
        $error("steering_pwm_gen: illegal PERIOD_CYCLES/CENTER_CYCLES/MAX_DEV/SLEW_STEP");
    end

    localparam logic signed [47:0] MAX_DEV_48 = 48'(MAX_DEV);
    localparam logic signed [31:0] MAX_DEV_32 = 32'(MAX_DEV);
    localparam logic signed [32:0] SLEW_33    = 33'(SLEW_STEP);
    localparam logic signed [31:0] SLEW_32    = 32'(SLEW_STEP);
    localparam logic signed [31:0] CENTER_32  = 32'(CENTER_CYCLES);
    localparam logic [31:0]        CENTER_U   = 32'(CENTER_CYCLES);
    localparam logic [31:0]        CNT_LAST   = 32'(PERIOD_CYCLES - 1);

    logic                en_q;
    logic [31:0]         cnt;
    logic signed [31:0]  dev;
    logic signed [31:0]  target;
    logic signed [31:0]  dev_next;
    logic signed [47:0]  pid_cmd;

    function automatic logic signed [31:0] clamp_cmd(input logic signed [47:0] cmd);
        if (cmd > MAX_DEV_48)
            return MAX_DEV_32;
        else if (cmd < -MAX_DEV_48)
            return -MAX_DEV_32;
        else
            return signed'(cmd[31:0]);
    endfunction

    function automatic logic is_clamped(input logic signed [47:0] cmd);
        return (cmd > MAX_DEV_48) || (cmd < -MAX_DEV_48);
    endfunction

    // Difference is taken one bit wider so target-dev can never wrap.
    function automatic logic signed [31:0] slew_dev(input logic signed [31:0] tgt,
                                                    input logic signed [31:0] cur);
        logic signed [32:0] diff;
        diff = {tgt[31], tgt} - {cur[31], cur};
        if (diff > SLEW_33)
            return cur + SLEW_32;
        else if (diff < -SLEW_33)
            return cur - SLEW_32;
        else
            return tgt;
    endfunction

    assign pid_cmd  = signed'(i_pid_output);
    assign dev_next = slew_dev(target, dev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            cnt         <= '0;
            dev         <= '0;
            target      <= '0;
            o_saturated <= 1'b0;
            o_width     <= CENTER_U;
        end else begin
            en_q <= i_enable;
            if (i_pid_valid) begin
                target      <= clamp_cmd(pid_cmd);
                o_saturated <= is_clamped(pid_cmd);
            end
            // Deviation and width only move at the period boundary, using the pre-edge target.
            if (!en_q) begin
                cnt     <= '0;
                dev     <= '0;
                o_width <= CENTER_U;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                dev     <= dev_next;
                o_width <= unsigned'(CENTER_32 + dev_next);
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

    assign o_pwm          = en_q && (cnt < o_width);
    assign o_period_start = en_q && (cnt == '0);

endmodule

// File: tb/tb_steering_pwm_gen.sv
// Directed bench for steering_pwm_gen with a 100-cycle period, center 30, max dev 10, slew 4.
module tb_steering_pwm_gen;

    logic        clk;
    logic        rst_n;
    logic        i_enable;
    logic        i_pid_valid;
    logic [47:0] i_pid_output;
    logic        o_pwm;
    logic        o_period_start;
    logic [31:0] o_width;
    logic        o_saturated;

    int errors = 0;
    int checks = 0;

    steering_pwm_gen #(
        .PERIOD_CYCLES(100),
        .CENTER_CYCLES(30),
        .MAX_DEV(10),
        .SLEW_STEP(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_enable(i_enable),
        .i_pid_valid(i_pid_valid),
        .i_pid_output(i_pid_output),
        .o_pwm(o_pwm),
        .o_period_start(o_period_start),
        .o_width(o_width),
        .o_saturated(o_saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits (bounded) until the sample shows cnt=0 of an enabled period.
    task automatic sync_start(input string tag);
        int k;
        k = 0;
        while (o_period_start !== 1'b1 && k < 300) begin
            step(1);
            k++;
        end
        checks++;
        if (o_period_start !== 1'b1) begin
            errors++;
            $display("FAIL %s_sync: o_period_start=%b required 1", tag, o_period_start);
        end
    endtask

    // Runs exactly one period from cnt=0 and leaves the bench at cnt=0 of the next one.
    task automatic run_period(input int v_at, input logic signed [47:0] v_val,
                              input int v2_at, input logic signed [47:0] v2_val,
                              output int hi, output int w, output int ps);
        w  = int'(o_width);
        hi = 0;
        ps = 0;
        for (int k = 0; k < 100; k++) begin
            if (o_pwm === 1'b1) hi++;
            if (o_period_start === 1'b1) ps++;
            if (k == v_at) begin
                i_pid_valid  = 1'b1;
                i_pid_output = v_val;
            end else if (k == v2_at) begin
                i_pid_valid  = 1'b1;
                i_pid_output = v2_val;
            end else begin
                i_pid_valid = 1'b0;
            end
            step(1);
        end
        i_pid_valid = 1'b0;
    endtask

    task automatic do_reset();
        i_enable     = 1'b0;
        i_pid_valid  = 1'b0;
        i_pid_output = '0;
        rst_n        = 1'b0;
        step(2);
        rst_n    = 1'b1;
        i_enable = 1'b1;
        sync_start("reset");
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        i_enable     = 1'b0;
        i_pid_valid  = 1'b0;
        i_pid_output = '0;
        step(3);
        checks++;
        if (o_pwm !== 1'b0 || o_period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pwm=%b start=%b required 0 0", o_pwm, o_period_start);
        end
        checks++;
        if (o_width !== 32'd30 || o_saturated !== 1'b0) begin
            errors++;
            $display("FAIL reset_width: width=%0d sat=%b required 30 0", o_width, o_saturated);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int hi, w, ps;
        rst_n    = 1'b1;
        i_enable = 1'b1;
        sync_start("case1");
        run_period(5, 48'sd8, -1, '0, hi, w, ps);
        step(10);
        checks++;
        if (o_pwm !== 1'b1 || o_width !== 32'd34) begin
            errors++;
            $display("FAIL c1_pre_reset: pwm=%b width=%0d required 1 34", o_pwm, o_width);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_pwm !== 1'b0 || o_width !== 32'd30 || o_period_start !== 1'b0) begin
            errors++;
            $display("FAIL c1_async_reset: pwm=%b width=%0d start=%b required 0 30 0",
                     o_pwm, o_width, o_period_start);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sync_start("case1_rel");
        for (int p = 0; p < 3; p++) begin
            run_period(-1, '0, -1, '0, hi, w, ps);
            checks++;
            if (w != 30 || hi != 30 || ps != 1 || o_period_start !== 1'b1) begin
                errors++;
                $display("FAIL c1_period%0d: width=%0d high=%0d starts=%0d next_start=%b required 30 30 1 1",
                         p, w, hi, ps, o_period_start);
            end
        end
    endtask

    task automatic test_slew_small();
        int hi, w, ps;
        int exp_w[4] = '{30, 34, 38, 38};
        do_reset();
        for (int p = 0; p < 4; p++) begin
            run_period(p == 0 ? 5 : -1, 48'sd8, -1, '0, hi, w, ps);
            checks++;
            if (w != exp_w[p] || hi != exp_w[p]) begin
                errors++;
                $display("FAIL c2_period%0d: width=%0d high=%0d required %0d", p, w, hi, exp_w[p]);
            end
        end
        checks++;
        if (o_saturated !== 1'b0) begin
            errors++;
            $display("FAIL c2_sat: sat=%b required 0", o_saturated);
        end
    endtask

    task automatic test_saturation();
        int hi, w, ps;
        int exp_up[5] = '{30, 34, 38, 40, 40};
        int exp_dn[7] = '{40, 36, 32, 28, 24, 20, 20};
        do_reset();
        for (int p = 0; p < 5; p++) begin
            run_period(p == 0 ? 5 : -1, 48'sd1000, -1, '0, hi, w, ps);
            checks++;
            if (w != exp_up[p] || hi != exp_up[p]) begin
                errors++;
                $display("FAIL c3_up%0d: width=%0d high=%0d required %0d", p, w, hi, exp_up[p]);
            end
        end
        checks++;
        if (o_saturated !== 1'b1) begin
            errors++;
            $display("FAIL c3_sat_pos: sat=%b required 1", o_saturated);
        end
        for (int p = 0; p < 7; p++) begin
            run_period(p == 0 ? 5 : -1, -48'sd1000, -1, '0, hi, w, ps);
            checks++;
            if (w != exp_dn[p] || hi != exp_dn[p]) begin
                errors++;
                $display("FAIL c3_down%0d: width=%0d high=%0d required %0d", p, w, hi, exp_dn[p]);
            end
        end
        checks++;
        if (o_saturated !== 1'b1) begin
            errors++;
            $display("FAIL c3_sat_neg: sat=%b required 1", o_saturated);
        end
        run_period(5, 48'sd3, -1, '0, hi, w, ps);
        checks++;
        if (o_saturated !== 1'b0 || o_width !== 32'd24) begin
            errors++;
            $display("FAIL c3_unsat: sat=%b width=%0d required 0 24", o_saturated, o_width);
        end
    endtask

    task automatic test_valid_at_wrap();
        int hi, w, ps;
        int exp_w[3] = '{30, 30, 34};
        do_reset();
        for (int p = 0; p < 3; p++) begin
            run_period(p == 0 ? 99 : -1, 48'sd8, -1, '0, hi, w, ps);
            checks++;
            if (w != exp_w[p]) begin
                errors++;
                $display("FAIL c4_period%0d: width=%0d required %0d", p, w, exp_w[p]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int hi, w, ps;
        int exp_w[4] = '{30, 26, 22, 22};
        do_reset();
        run_period(5, 48'sd8, -1, '0, hi, w, ps);
        step(10);
        i_enable = 1'b0;
        step(1);
        checks++;
        if (o_pwm !== 1'b0) begin
            errors++;
            $display("FAIL c5_drop_pwm: pwm=%b required 0", o_pwm);
        end
        step(3);
        checks++;
        if (o_pwm !== 1'b0 || o_period_start !== 1'b0 || o_width !== 32'd30) begin
            errors++;
            $display("FAIL c5_disabled: pwm=%b start=%b width=%0d required 0 0 30",
                     o_pwm, o_period_start, o_width);
        end
        i_pid_valid  = 1'b1;
        i_pid_output = -48'sd8;
        step(1);
        i_pid_valid = 1'b0;
        step(5);
        i_enable = 1'b1;
        sync_start("case5");
        for (int p = 0; p < 4; p++) begin
            run_period(-1, '0, -1, '0, hi, w, ps);
            checks++;
            if (w != exp_w[p] || hi != exp_w[p]) begin
                errors++;
                $display("FAIL c5_period%0d: width=%0d high=%0d required %0d", p, w, hi, exp_w[p]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hi, w, ps;
        do_reset();
        run_period(5, 48'sd8, 40, -48'sd8, hi, w, ps);
        checks++;
        if (w != 30) begin
            errors++;
            $display("FAIL c6_first: width=%0d required 30", w);
        end
        run_period(-1, '0, -1, '0, hi, w, ps);
        checks++;
        if (w != 26 || hi != 26) begin
            errors++;
            $display("FAIL c6_second: width=%0d high=%0d required 26", w, hi);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_pulse();
        test_slew_small();
        test_saturation();
        test_valid_at_wrap();
        test_enable_drop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/steering_pwm_gen.md
STEERING_PWM_GEN -- requirements
Module: steering_pwm_gen

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 2000000, meaning clock cycles per PWM period (20 ms at 100 MHz).
REQ-002 SHALL have parameter CENTER_CYCLES, default 150000, meaning the pulse width for zero steering.
REQ-003 SHALL have parameter MAX_DEV, default 50000, meaning the maximum pulse-width deviation from center in cycles.
REQ-004 SHALL have parameter SLEW_STEP, default 1000, meaning the maximum change in deviation per period, in cycles.
REQ-005 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have i_enable, input, 1, which runs PWM generation while high.
REQ-008 SHALL have i_pid_valid, input, 1, a one-cycle strobe qualifying i_pid_output.
REQ-009 SHALL have i_pid_output, input, 48, the signed steering command in pulse-width cycles from the PID stage.
REQ-010 SHALL have o_pwm, output, 1, the servo pulse.
REQ-011 SHALL have o_period_start, output, 1, a one-cycle pulse at the first cycle of each enabled period.
REQ-012 SHALL have o_width, output, 32, the unsigned pulse width currently applied.
REQ-013 SHALL have o_saturated, output, 1, high when the last accepted command was clamped.

Function
REQ-014 SHALL hold a registered copy en_q of i_enable; all enable-dependent behaviour SHALL key off en_q.
REQ-015 SHALL run a period counter cnt from 0 to PERIOD_CYCLES-1 and then wrap to 0 while en_q=1.
REQ-016 SHALL hold cnt at 0 while en_q=0.
REQ-017 SHALL, on a clock edge with i_pid_valid=1, load target with i_pid_output clamped to [-MAX_DEV, +MAX_DEV] (signed 48-bit compare).
REQ-018 SHALL, on that same edge, set o_saturated to 1 if the clamp was active and to 0 otherwise; o_saturated SHALL hold its value until the next valid.
REQ-019 SHALL update the applied deviation dev only on the edge where cnt wraps from PERIOD_CYCLES-1 to 0.
REQ-020 SHALL compute the update as follows: if target-dev > SLEW_STEP then dev += SLEW_STEP; else if target-dev < -SLEW_STEP then dev -= SLEW_STEP; else dev = target.
REQ-021 SHALL make the wrap-edge update use the target held before that edge, so a valid coinciding with cnt=PERIOD_CYCLES-1 first affects the following boundary.
REQ-022 SHALL drive o_width = CENTER_CYCLES + dev, as a registered value that changes only on wrap edges, on en_q transitions, or on reset.
REQ-023 SHALL drive o_pwm = en_q AND (cnt < o_width), glitch-free because it is decoded from registers only.
REQ-024 SHALL drive o_period_start = en_q AND (cnt = 0).
REQ-025 SHALL, while en_q=0, force dev to 0 and o_pwm to 0; target SHALL keep accepting valid commands.
REQ-026 SHALL, when en_q rises, start a period at cnt=0 with width CENTER_CYCLES; slewing toward target resumes at the first wrap.
REQ-027 SHALL require CENTER_CYCLES >= MAX_DEV, CENTER_CYCLES + MAX_DEV < PERIOD_CYCLES and SLEW_STEP >= 1; any other setting is illegal and SHALL be flagged by an elaboration-time check.
REQ-028 SHALL hold dev to 32-bit signed and never let it exceed ±MAX_DEV.

Reset
REQ-029 SHALL, with rst_n low, immediately clear en_q, cnt, dev, target and o_saturated; o_pwm=0, o_period_start=0, o_width=CENTER_CYCLES.
REQ-030 SHALL treat reset mid-pulse as aborting the pulse in the same instant, with no completion of the current period.
REQ-031 SHALL, after rst_n rises, begin operation on the first edge where i_enable is sampled high.

Verification (PERIOD_CYCLES=100, CENTER_CYCLES=30, MAX_DEV=10, SLEW_STEP=4)
REQ-032 Case 1: assert rst_n low mid-pulse -> o_pwm=0 and o_width=30 immediately; after release with enable high, o_period_start pulses every 100 cycles and o_pwm is high for 30 cycles.
REQ-033 Case 2: enable high, then valid with +8 -> o_width sequence over successive periods is 30, 34, 38, 38; o_saturated=0.
REQ-034 Case 3: valid with +1000 -> o_saturated=1 and o_width steps 34, 38, 40, 40; then valid with -1000 -> o_width steps 36, 32, ..., 20 and holds at 20.
REQ-035 Case 4: valid with +8 exactly at cnt=99 -> the next period is still 30 and the one after is 34.
REQ-036 Case 5: i_enable dropped at cnt=10 during a pulse -> o_pwm low from the following cycle and cnt held at 0; re-enable -> first period width 30, then slewing resumes toward the stored target.
REQ-037 Case 6: two valids in one period (+8, then -8) -> only -8 is used at the boundary and o_width becomes 26.
